// File: rtl/stage_sample_mixer.sv
// Carrier mixer: scales carrier operator outputs by 1/N, sums them per frame, shifts/saturates, queues samples.
// Latency: last slot at cycle t -> o_SampleValid at t+MULT_LATENCY+2 (empty FIFO). Input never stalls; full FIFO drops new frames and sets o_Overrun.
module stage_sample_mixer #(
    parameter int NUM_VOICES    = 32,
    parameter int NUM_OPERATORS = 8,
    parameter int OUT_WIDTH     = 16,
    parameter int GUARD_BITS    = 5,
    parameter int OUTPUT_SHIFT  = 5,
    parameter int MULT_LATENCY  = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                                        i_Clock,
    input  logic                                        i_Reset,
    input  logic                                        i_Valid,
    input  logic [$clog2(NUM_VOICES*NUM_OPERATORS)-1:0] i_VoiceOperator,
    input  logic                                        i_IsCarrier,
    input  logic [$clog2(NUM_OPERATORS):0]              i_NumCarriers,
    input  logic [15:0]                                 i_OperatorOutput,
    input  logic                                        i_ClearStatus,
    output logic                                        o_SampleValid,
    input  logic                                        i_SampleReady,
    output logic [OUT_WIDTH-1:0]                        o_Sample,
    output logic                                        o_Clip,
    output logic                                        o_Overrun
);

    localparam int NUM_SLOTS = NUM_VOICES * NUM_OPERATORS;
    localparam int SLOT_W    = $clog2(NUM_SLOTS);
    localparam int NC_W      = $clog2(NUM_OPERATORS) + 1;
    localparam int ACC_W     = 16 + GUARD_BITS;
    localparam int NSTG      = MULT_LATENCY - 1;
    localparam int PTR_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int AW        = PTR_W - 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam int SAT_MAX_I = (1 << (OUT_WIDTH - 1)) - 1;
    localparam int SAT_MIN_I = -(1 << (OUT_WIDTH - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(SAT_MAX_I);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(SAT_MIN_I);

    function automatic logic [15:0] comp_factor(input int n);
        int d;
        d = (n == 0) ? 1 : n;
        if ((32768 / d) > 32767) return 16'h7FFF;
        return 16'(32768 / d);
    endfunction

    logic [15:0] w_FactorTable [2**NC_W];
    generate
        for (genvar g = 0; g < 2**NC_W; g++) begin : g_factor
            assign w_FactorTable[g] = comp_factor(g);
        end
    endgenerate

    logic        [15:0] w_Factor;
    logic signed [31:0] w_Product;
    assign w_Factor  = w_FactorTable[i_NumCarriers];
    // F never exceeds 0x7FFF, so treating it as signed keeps it positive.
    assign w_Product = $signed(w_Factor) * $signed(i_OperatorOutput);

    logic signed [31:0] r_Prod [NSTG];
    logic [NSTG-1:0]    r_PipeValid;
    logic [NSTG-1:0]    r_PipeCarrier;
    logic [NSTG-1:0]    r_PipeEof;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            for (int k = 0; k < NSTG; k++) r_Prod[k] <= '0;
            r_PipeValid   <= '0;
            r_PipeCarrier <= '0;
            r_PipeEof     <= '0;
        end else begin
            r_Prod[0]        <= w_Product;
            r_PipeValid[0]   <= i_Valid;
            r_PipeCarrier[0] <= i_Valid & i_IsCarrier;
            r_PipeEof[0]     <= i_Valid && (i_VoiceOperator == LAST_SLOT);
            for (int k = 1; k < NSTG; k++) begin
                r_Prod[k]        <= r_Prod[k-1];
                r_PipeValid[k]   <= r_PipeValid[k-1];
                r_PipeCarrier[k] <= r_PipeCarrier[k-1];
                r_PipeEof[k]     <= r_PipeEof[k-1];
            end
        end
    end

    logic signed [31:0]      w_Tail;
    logic signed [ACC_W-1:0] w_Contrib;
    logic signed [ACC_W-1:0] w_AccBase;
    logic                    w_unused_prod_bits;
    logic signed [ACC_W-1:0] r_Acc;
    logic                    r_FrameStart;
    logic                    r_AccDone;

    assign w_Tail             = r_Prod[NSTG-1];
    assign w_Contrib          = {{GUARD_BITS{w_Tail[30]}}, w_Tail[30:15]};
    assign w_AccBase          = r_FrameStart ? '0 : r_Acc;
    assign w_unused_prod_bits = ^{w_Tail[31], w_Tail[14:0]};

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_Acc        <= '0;
            r_FrameStart <= 1'b1;
            r_AccDone    <= 1'b0;
        end else begin
            r_AccDone <= r_PipeValid[NSTG-1] & r_PipeEof[NSTG-1];
            if (r_PipeValid[NSTG-1]) begin
                r_Acc        <= w_AccBase + (r_PipeCarrier[NSTG-1] ? w_Contrib : '0);
                r_FrameStart <= r_PipeEof[NSTG-1];
            end
        end
    end

    logic signed [ACC_W-1:0] w_Shifted;
    logic                    w_SatHigh;
    logic                    w_SatLow;
    logic [OUT_WIDTH-1:0]    w_SatSample;
    logic                    w_ClipSet;
    logic                    r_SatValid;
    logic [OUT_WIDTH-1:0]    r_SatSample;

    assign w_Shifted   = r_Acc >>> OUTPUT_SHIFT;
    assign w_SatHigh   = w_Shifted > SAT_MAX;
    assign w_SatLow    = w_Shifted < SAT_MIN;
    assign w_SatSample = w_SatHigh ? OUT_WIDTH'(SAT_MAX) :
                         w_SatLow  ? OUT_WIDTH'(SAT_MIN) : w_Shifted[OUT_WIDTH-1:0];
    assign w_ClipSet   = r_AccDone & (w_SatHigh | w_SatLow);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_SatValid  <= 1'b0;
            r_SatSample <= '0;
        end else begin
            r_SatValid  <= r_AccDone;
            r_SatSample <= w_SatSample;
        end
    end

    logic [OUT_WIDTH-1:0] r_Mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_WrPtr;
    logic [PTR_W-1:0]     r_RdPtr;
    logic                 w_Empty;
    logic                 w_Full;
    logic                 w_Pop;
    logic                 w_Push;
    logic                 w_Drop;

    assign w_Empty = (r_WrPtr == r_RdPtr);
    assign w_Full  = (r_WrPtr[AW] != r_RdPtr[AW]) && (r_WrPtr[AW-1:0] == r_RdPtr[AW-1:0]);
    assign w_Pop   = !w_Empty & i_SampleReady;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts then.
    assign w_Push  = r_SatValid & (!w_Full | w_Pop);
    assign w_Drop  = r_SatValid & w_Full & !w_Pop;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            for (int k = 0; k < FIFO_DEPTH; k++) r_Mem[k] <= '0;
            r_WrPtr <= '0;
            r_RdPtr <= '0;
        end else begin
            if (w_Push) begin
                r_Mem[r_WrPtr[AW-1:0]] <= r_SatSample;
                r_WrPtr                <= r_WrPtr + 1'b1;
            end
            if (w_Pop) r_RdPtr <= r_RdPtr + 1'b1;
        end
    end

    logic r_Clip;
    logic r_Overrun;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_Clip    <= 1'b0;
            r_Overrun <= 1'b0;
        end else begin
            r_Clip    <= w_ClipSet | (r_Clip & !i_ClearStatus);
            r_Overrun <= w_Drop | (r_Overrun & !i_ClearStatus);
        end
    end

    assign o_SampleValid = !w_Empty;
    assign o_Sample      = r_Mem[r_RdPtr[AW-1:0]];
    assign o_Clip        = r_Clip;
    assign o_Overrun     = r_Overrun;

endmodule

// File: tb/tb_stage_sample_mixer.sv
// Bench for stage_sample_mixer: two instances (shift 5 and shift 0) share one stimulus and one frame-level model.
module tb_stage_sample_mixer;
    localparam int ML    = 4;
    localparam int LAST  = 255;
    localparam int DEPTH = 4;

    logic        i_Clock = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_Valid = 1'b0;
    logic [7:0]  i_VoiceOperator = '0;
    logic        i_IsCarrier = 1'b0;
    logic [3:0]  i_NumCarriers = 4'd1;
    logic [15:0] i_OperatorOutput = '0;
    logic        i_ClearStatus = 1'b0;
    logic        i_SampleReady = 1'b1;
    logic        v0, v1, c0, c1, ov0, ov1;
    logic [15:0] s0, s1;

    stage_sample_mixer dut0 (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Valid(i_Valid),
        .i_VoiceOperator(i_VoiceOperator), .i_IsCarrier(i_IsCarrier),
        .i_NumCarriers(i_NumCarriers), .i_OperatorOutput(i_OperatorOutput),
        .i_ClearStatus(i_ClearStatus), .o_SampleValid(v0), .i_SampleReady(i_SampleReady),
        .o_Sample(s0), .o_Clip(c0), .o_Overrun(ov0));

    stage_sample_mixer #(.OUTPUT_SHIFT(0)) dut1 (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Valid(i_Valid),
        .i_VoiceOperator(i_VoiceOperator), .i_IsCarrier(i_IsCarrier),
        .i_NumCarriers(i_NumCarriers), .i_OperatorOutput(i_OperatorOutput),
        .i_ClearStatus(i_ClearStatus), .o_SampleValid(v1), .i_SampleReady(i_SampleReady),
        .o_Sample(s1), .o_Clip(c1), .o_Overrun(ov1));

    always #5 i_Clock = ~i_Clock;

    int cyc = 0;
    always @(posedge i_Clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic taken straight from the behavioural rules
    function automatic int cval(input int n, input int op);
        int nn, f, ops;
        nn  = (n == 0) ? 1 : n;
        f   = 32768 / nn;
        if (f > 32767) f = 32767;
        ops = (op >= 32768) ? op - 65536 : op;
        return (f * ops) >>> 15;
    endfunction

    function automatic int wrap21(input int x);
        int y;
        y = x & ((1 << 21) - 1);
        if (y >= (1 << 20)) y = y - (1 << 21);
        return y;
    endfunction

    function automatic int sat(input int acc, input int sh);
        int s;
        s = acc >>> sh;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    function automatic bit clips(input int acc, input int sh);
        return ((acc >>> sh) > 32767) || ((acc >>> sh) < -32768);
    endfunction

    typedef struct { int edge_c; int acc; } push_t;
    push_t pend[$];
    int    q[$];
    bit    pop_pend = 1'b0;
    int    frame_sum = 0;
    bit    clip_exp0 = 1'b0;
    bit    clip_exp1 = 1'b0;
    bit    ovr_exp = 1'b0;
    int    last_cyc = 0;
    bit    mon_en = 1'b0;
    bit    rand_ready = 1'b0;

    bit car_a [256];
    int n_a   [256];
    int op_a  [256];

    always @(negedge i_Clock) begin
        int    cnt;
        bit    vexp;
        push_t p;
        if (mon_en && !i_Reset) begin
            cnt = q.size();
            if (pop_pend) void'(q.pop_front());
            while (pend.size() > 0 && pend[0].edge_c <= cyc) begin
                p = pend.pop_front();
                if (clips(p.acc, 5)) clip_exp0 = 1'b1;
                if (clips(p.acc, 0)) clip_exp1 = 1'b1;
                if (cnt < DEPTH || pop_pend) q.push_back(p.acc);
                else ovr_exp = 1'b1;
            end
            vexp = (q.size() != 0);
            chk("mon_vld0", {31'd0, v0}, {31'd0, vexp});
            chk("mon_vld1", {31'd0, v1}, {31'd0, vexp});
            if (vexp) begin
                chk("mon_smp0", {16'd0, s0}, sat(q[0], 5) & 32'hFFFF);
                chk("mon_smp1", {16'd0, s1}, sat(q[0], 0) & 32'hFFFF);
            end
            pop_pend = vexp && i_SampleReady;
        end
    end

    task automatic drive_slot(input bit v, input int idx, input bit car, input int n, input int op);
        push_t p;
        @(posedge i_Clock);
        #1;
        if (rand_ready) i_SampleReady = 1'($urandom_range(0, 1));
        i_Valid          = v;
        i_VoiceOperator  = 8'(idx);
        i_IsCarrier      = car;
        i_NumCarriers    = 4'(n);
        i_OperatorOutput = 16'(op);
        if (v) begin
            if (car) frame_sum = wrap21(frame_sum + cval(n, op));
            if (idx == LAST) begin
                p.edge_c  = cyc + ML + 2;
                p.acc     = frame_sum;
                pend.push_back(p);
                last_cyc  = cyc;
                frame_sum = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive_slot(1'b0, $urandom_range(0, 255), 1'($urandom_range(0, 1)),
                              $urandom_range(1, 8), $urandom_range(0, 65535));
    endtask

    task automatic fill_quiet();
        for (int s = 0; s < 256; s++) begin
            car_a[s] = 1'b0;
            n_a[s]   = $urandom_range(0, 8);
            op_a[s]  = $urandom_range(0, 65535);
        end
    endtask

    task automatic play_frame(input int bubble_pct, input bit forced);
        for (int s = 0; s < 256; s++) begin
            while ($urandom_range(0, 99) < bubble_pct) idle(1);
            if (forced && s == LAST) drive_slot(1'b0, LAST, 1'b1, 1, 16'h7FFF);
            drive_slot(1'b1, s, car_a[s], n_a[s], op_a[s]);
        end
    endtask

    task automatic wait_sample(input string tag);
        int k;
        k = 0;
        while (!v0 && k < 30) begin
            idle(1);
            k++;
        end
        chk(tag, {31'd0, v0}, 32'd1);
    endtask

    task automatic clear_status();
        @(posedge i_Clock);
        #1;
        i_Valid       = 1'b0;
        i_ClearStatus = 1'b1;
        @(posedge i_Clock);
        #1;
        i_ClearStatus = 1'b0;
        clip_exp0 = 1'b0;
        clip_exp1 = 1'b0;
        ovr_exp   = 1'b0;
    endtask

    task automatic setup_t1();
        fill_quiet();
        car_a[5] = 1'b1; n_a[5] = 1; op_a[5] = 16'h4000;
    endtask

    task automatic setup_t2();
        fill_quiet();
        for (int o = 0; o < 8; o++) begin
            n_a[24+o]   = 4;
            car_a[24+o] = (o < 4);
            if (o < 4) op_a[24+o] = 16'h7FFF;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_vld0"}, {31'd0, v0}, 0);
        chk({tag, "_vld1"}, {31'd0, v1}, 0);
        chk({tag, "_smp0"}, {16'd0, s0}, 0);
        chk({tag, "_smp1"}, {16'd0, s1}, 0);
        chk({tag, "_clip0"}, {31'd0, c0}, 0);
        chk({tag, "_clip1"}, {31'd0, c1}, 0);
        chk({tag, "_ovr0"}, {31'd0, ov0}, 0);
        chk({tag, "_ovr1"}, {31'd0, ov1}, 0);
    endtask

    initial begin
        int exp_a [4];
        repeat (3) @(posedge i_Clock);
        #1;
        check_reset_outputs("rst");
        i_Reset = 1'b0;
        mon_en  = 1'b1;

        // single carrier, exact latency
        setup_t1();
        play_frame(0, 1'b0);
        wait_sample("t1_arrive");
        chk("t1_latency", cyc - last_cyc, ML + 2);
        chk("t1_smp0", {16'd0, s0}, 32'h01FF);
        chk("t1_smp1", {16'd0, s1}, 32'h3FFF);
        chk("t1_clip0", {31'd0, c0}, 0);
        idle(5);

        // one voice, four carriers with N=4
        setup_t2();
        play_frame(0, 1'b0);
        wait_sample("t2_arrive");
        chk("t2_smp0", {16'd0, s0}, 32'h03FF);
        chk("t2_smp1", {16'd0, s1}, 32'h7FFC);
        idle(5);

        // saturation on the shift-0 instance
        fill_quiet();
        car_a[0] = 1'b1; n_a[0] = 1; op_a[0] = 16'h7FFF;
        car_a[8] = 1'b1; n_a[8] = 1; op_a[8] = 16'h7FFF;
        play_frame(0, 1'b0);
        wait_sample("t3_arrive");
        chk("t3_smp1", {16'd0, s1}, 32'h7FFF);
        chk("t3_smp0", {16'd0, s0}, 32'h07FF);
        idle(3);
        chk("t3_clip1", {31'd0, c1}, 1);
        chk("t3_clip0", {31'd0, c0}, 0);
        op_a[0] = 16'h8000; op_a[8] = 16'h8000;
        play_frame(0, 1'b0);
        wait_sample("t3b_arrive");
        chk("t3b_smp1", {16'd0, s1}, 32'h8000);
        chk("t3b_smp0", {16'd0, s0}, 32'hF800);
        idle(3);
        clear_status();
        chk("t3_clr_clip1", {31'd0, c1}, 0);

        // back-pressure: five frames into a four-deep FIFO
        i_SampleReady = 1'b0;
        for (int f = 0; f < 5; f++) begin
            fill_quiet();
            car_a[0] = 1'b1; n_a[0] = 1; op_a[0] = 16'h1000 * (f + 1);
            if (f < 4) exp_a[f] = sat(cval(1, 16'h1000 * (f + 1)), 5) & 32'hFFFF;
            play_frame(0, 1'b0);
        end
        idle(10);
        chk("t4_ovr0", {31'd0, ov0}, 1);
        chk("t4_ovr1", {31'd0, ov1}, 1);
        chk("t4_ovr_model", {31'd0, ov0}, {31'd0, ovr_exp});
        i_SampleReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_order_vld", {31'd0, v0}, 1);
            chk("t4_order_smp", {16'd0, s0}, exp_a[i]);
            idle(1);
        end
        chk("t4_e_absent", {31'd0, v0}, 0);
        clear_status();
        chk("t4_ovr_clr", {31'd0, ov0}, 0);

        // bubbles, including a bubble carrying the last index
        setup_t1();
        play_frame(20, 1'b1);
        wait_sample("t5_arrive");
        chk("t5_smp0", {16'd0, s0}, 32'h01FF);
        idle(20);
        chk("t5_no_extra", {31'd0, v0}, 0);

        // randomized frames with random ready
        rand_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            fill_quiet();
            for (int s = 0; s < 256; s++) car_a[s] = ($urandom_range(0, 3) == 0);
            play_frame(10, 1'b0);
        end
        rand_ready    = 1'b0;
        i_SampleReady = 1'b1;
        idle(20);
        chk("rnd_clip0", {31'd0, c0}, {31'd0, clip_exp0});
        chk("rnd_clip1", {31'd0, c1}, {31'd0, clip_exp1});
        chk("rnd_ovr0", {31'd0, ov0}, {31'd0, ovr_exp});
        chk("rnd_drained", {31'd0, v0}, 0);

        // reset mid-frame with samples queued
        i_SampleReady = 1'b0;
        setup_t2();
        play_frame(0, 1'b0);
        play_frame(0, 1'b0);
        idle(10);
        chk("t6_queued", {31'd0, v0}, 1);
        setup_t2();
        for (int s = 0; s < 100; s++) drive_slot(1'b1, s, car_a[s], n_a[s], op_a[s]);
        @(posedge i_Clock);
        #3;
        i_Reset = 1'b1;
        #1;
        check_reset_outputs("t6_rst");
        q.delete();
        pend.delete();
        pop_pend  = 1'b0;
        frame_sum = 0;
        clip_exp0 = 1'b0;
        clip_exp1 = 1'b0;
        ovr_exp   = 1'b0;
        repeat (2) @(posedge i_Clock);
        #1;
        i_Valid = 1'b0;
        i_Reset = 1'b0;
        i_SampleReady = 1'b1;
        setup_t2();
        play_frame(0, 1'b0);
        wait_sample("t6_arrive");
        chk("t6_smp0", {16'd0, s0}, 32'h03FF);
        idle(10);
        chk("t6_single", {31'd0, v0}, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1);
    end
endmodule
